// File: rtl/width_trans_pkg.sv
// Shared constants and helpers for the stream width translators.
// Lane ordering lives here so every expander packs beats the same way.
package width_trans_pkg;

    localparam int ACT_USE_W = 16;
    localparam int WEI_USE_W = 32;
    localparam int ARRAY_W   = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int lane_idx(
        input int lc,
        input int ratio,
        input bit msb_first
    );
        return msb_first ? ratio - 1 - lc : lc;
    endfunction

endpackage

// File: rtl/axis_upsizer_fifo_if.sv
// AXI-Stream bundle shared by the narrow input and wide output sides.
// Unused sideband fields are simply left unread by the consumer.
interface axis_upsizer_fifo_if #(
    parameter int DW = 32,
    parameter int KW = 1
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;

    modport master (
        output tvalid, tdata, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast,
        output tready
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// level counts every stored word, including the one being presented.
module sync_fifo_fwft
    import width_trans_pkg::*;
#(
    parameter int WIDTH     = 137,
    parameter int DEPTH     = 512,
    parameter int PF_THRESH = DEPTH - 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    output logic                        wr_ready,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [WIDTH-1:0]            rd_data,
    output logic [clog2(DEPTH+1)-1:0]   level,
    output logic                        prog_full
);
    localparam int PW  = clog2(DEPTH);
    localparam int LVW = clog2(DEPTH + 1);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 4");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [LVW-1:0]   lvl_nxt;
    logic [LVW-1:0]   avail;
    logic             wr;
    logic             pop;

    assign wr  = wr_en & wr_ready;
    assign pop = rd_valid & rd_ready;

    always_comb begin
        rd_nxt  = rd_ptr + PW'(pop);
        avail   = level - LVW'(pop);
        lvl_nxt = level + LVW'(wr) - LVW'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    // Head reloads from the new read pointer every edge; a stalled head
    // re-reads its own slot, which writes never touch while occupied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            prog_full <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(wr);
            rd_ptr    <= rd_nxt;
            level     <= lvl_nxt;
            prog_full <= int'(lvl_nxt) >= PF_THRESH;
            wr_ready  <= lvl_nxt != LVW'(DEPTH);
            rd_valid  <= avail != '0;
            if (avail != '0) rd_data <= mem[rd_nxt];
        end
    end

endmodule

// File: rtl/axis_upsizer_fifo.sv
// AXI-Stream upsizer: packs RATIO narrow beats into one wide word,
// flushing early on tlast, and queues words in a FWFT FIFO.
module axis_upsizer_fifo
    import width_trans_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int USE_W     = 16,
    parameter int OUT_W     = 128,
    parameter int DEPTH     = 512,
    parameter int PF_THRESH = DEPTH - 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axis_upsizer_fifo_if.slave        s,
    axis_upsizer_fifo_if.master       m,
    output logic [clog2(DEPTH+1)-1:0] level,
    output logic                      prog_full
);
    localparam int RATIO = OUT_W / USE_W;
    localparam int LCW   = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam int WIDTH = OUT_W + RATIO + 1;

    if (OUT_W % USE_W != 0) begin : g_bad_mult
        $error("OUT_W must be a multiple of USE_W");
    end
    if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
        $error("RATIO must be a power of two");
    end
    if (PF_THRESH > DEPTH) begin : g_bad_pf
        $error("PF_THRESH must not exceed DEPTH");
    end
    if (USE_W > IN_W) begin : g_bad_use
        $error("USE_W must not exceed IN_W");
    end

    logic [LCW-1:0]              lc;
    logic [LCW-1:0]              lane;
    logic [RATIO-1:0][USE_W-1:0] lanes;
    logic [RATIO-1:0][USE_W-1:0] lanes_n;
    logic [RATIO-1:0]            keep;
    logic [RATIO-1:0]            keep_n;
    logic                        wr_ready;
    logic                        accept;
    logic                        push;
    logic [WIDTH-1:0]            rd_data;

    assign s.tready = wr_ready;
    assign accept   = s.tvalid & wr_ready;
    assign push     = accept & ((lc == LCW'(RATIO - 1)) | s.tlast);

    always_comb begin
        lanes_n       = lanes;
        keep_n        = keep;
        lane          = LCW'(lane_idx(int'(lc), RATIO, MSB_FIRST != 0));
        lanes_n[lane] = s.tdata[USE_W-1:0];
        keep_n[lane]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || push) begin
            lc    <= '0;
            lanes <= '0;
            keep  <= '0;
        end else if (accept) begin
            lc    <= lc + LCW'(1);
            lanes <= lanes_n;
            keep  <= keep_n;
        end
    end

    sync_fifo_fwft #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PF_THRESH (PF_THRESH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   ({s.tlast, keep_n, lanes_n}),
        .wr_ready  (wr_ready),
        .rd_valid  (m.tvalid),
        .rd_ready  (m.tready),
        .rd_data   (rd_data),
        .level     (level),
        .prog_full (prog_full)
    );

    assign {m.tlast, m.tkeep, m.tdata} = rd_data;

    // Input bits above USE_W and the input-side tkeep carry no meaning here.
    logic unused_keep;
    assign unused_keep = ^s.tkeep;
    if (IN_W > USE_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^s.tdata[IN_W-1:USE_W];
    end

endmodule

// File: tb/tb_axis_upsizer_fifo.sv
// Bench for axis_upsizer_fifo: three instances (default, MSB-first, DEPTH=4).
// Directed table vectors, fill/drain wrap passes, random run vs a word queue.
module tb_axis_upsizer_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [2:0]            sv;
    logic [2:0]            sl;
    logic [2:0]            mr;
    logic [2:0][31:0]      sd;
    wire  [2:0]            st;
    wire  [2:0]            mv;
    wire  [2:0]            ml;
    wire  [2:0]            pf;
    wire  [2:0][127:0]     md;
    wire  [2:0][7:0]       mk;
    wire  [2:0][9:0]       lvl;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DEP = (g == 2) ? 4 : 512;
        localparam int PFT = (g == 2) ? 3 : DEP - 8;
        localparam int MSB = (g == 1) ? 1 : 0;

        axis_upsizer_fifo_if #(.DW(32), .KW(1)) s_if ();
        axis_upsizer_fifo_if #(.DW(128), .KW(8)) m_if ();
        wire [$clog2(DEP+1)-1:0] lv;

        assign s_if.tvalid = sv[g];
        assign s_if.tdata  = sd[g];
        assign s_if.tlast  = sl[g];
        assign s_if.tkeep  = 1'b1;
        assign m_if.tready = mr[g];
        assign st[g]       = s_if.tready;
        assign mv[g]       = m_if.tvalid;
        assign md[g]       = m_if.tdata;
        assign mk[g]       = m_if.tkeep;
        assign ml[g]       = m_if.tlast;
        assign lvl[g]      = 10'(lv);

        axis_upsizer_fifo #(
            .IN_W      (32),
            .USE_W     (16),
            .OUT_W     (128),
            .DEPTH     (DEP),
            .PF_THRESH (PFT),
            .MSB_FIRST (MSB)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .s         (s_if),
            .m         (m_if),
            .level     (lv),
            .prog_full (pf[g])
        );
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_tready", 128'(st[d]), 0);
        chk("rst_tvalid", 128'(mv[d]), 0);
        chk("rst_tdata", md[d], 0);
        chk("rst_tkeep", 128'(mk[d]), 0);
        chk("rst_tlast", 128'(ml[d]), 0);
        chk("rst_level", 128'(lvl[d]), 0);
        chk("rst_pfull", 128'(pf[d]), 0);
    endtask

    task automatic send_pkt(input int d, input int n,
                            input logic [7:0][15:0] b, input logic lst);
        for (int i = 0; i < n; i++) begin
            sv[d] = 1'b1;
            sd[d] = {16'hDEAD, b[i]};
            sl[d] = lst && (i == n - 1);
            for (int w = 0; w < 50 && !st[d]; w++) tick();
            if (!st[d]) chk("send_tready", 128'(st[d]), 1);
            tick();
        end
        sv[d] = 1'b0;
        sl[d] = 1'b0;
    endtask

    typedef struct {
        int              d;
        int              n;
        logic [7:0][15:0] b;
        logic [127:0]    w;
        logic [7:0]      k;
        logic            lst;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        logic [7:0]   k;
        logic         l;
    } word_t;

    // Reference for instance 2: beats gathered into words by count/tlast.
    word_t        q[$];
    int           mcnt = 0;
    logic [127:0] mwd  = '0;
    logic [7:0]   mwk  = '0;
    logic         last_acc = 1'b0;

    task automatic cyc2();
        logic         hold;
        logic [127:0] hd;
        logic [8:0]   hkl;
        word_t        e;
        last_acc = sv[2] & st[2];
        if (mv[2] && mr[2]) begin
            if (q.size() == 0) begin
                chk("pop_empty", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rdata", md[2], e.d);
                chk("rkeep_last", 128'({ml[2], mk[2]}), 128'({e.l, e.k}));
            end
        end
        if (last_acc) begin
            mwd[mcnt*16 +: 16] = sd[2][15:0];
            mwk[mcnt] = 1'b1;
            mcnt++;
            if (mcnt == 8 || sl[2]) begin
                q.push_back('{mwd, mwk, sl[2]});
                mcnt = 0;
                mwd  = '0;
                mwk  = '0;
            end
        end
        hold = mv[2] & ~mr[2];
        hd   = md[2];
        hkl  = {ml[2], mk[2]};
        tick();
        if (hold) begin
            chk("hold_valid", 128'(mv[2]), 1);
            chk("hold_data", md[2], hd);
            chk("hold_keep", 128'({ml[2], mk[2]}), 128'(hkl));
        end
        chk("level", 128'(lvl[2]), 128'(q.size()));
        chk("pfull", 128'(pf[2]), 128'(q.size() >= 3));
        chk("tready", 128'(st[2]), 128'(q.size() != 4));
    endtask

    vec_t vt[6];

    initial begin
        int beat;
        int acc;
        int seen;

        rst_n = 1'b0;
        sv = '0; sl = '0; mr = '0; sd = '0;

        vt[0] = '{0, 8, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
                  128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'hFF, 1'b1};
        vt[1] = '{1, 8, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
                  128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'hFF, 1'b1};
        vt[2] = '{0, 3, 128'h000C_000B_000A,
                  128'h000C_000B_000A, 8'h07, 1'b1};
        vt[3] = '{0, 2, 128'hBEEF_1234, 128'hBEEF_1234, 8'h03, 1'b1};
        vt[4] = '{1, 3, 128'h000C_000B_000A,
                  128'h000A_000B_000C_0000_0000_0000_0000_0000, 8'hE0, 1'b1};
        vt[5] = '{0, 8, 128'h8888_7777_6666_5555_4444_3333_2222_1111,
                  128'h8888_7777_6666_5555_4444_3333_2222_1111, 8'hFF, 1'b0};

        repeat (3) tick();
        for (int d = 0; d < 3; d++) chk_reset(d);
        rst_n = 1'b1;
        chk("tready_in_rst_edge", 128'(st), 0);
        tick();
        chk("tready_rise", 128'(st), 128'(3'b111));
        mr = 3'b111;

        for (int i = 0; i < 6; i++) begin
            send_pkt(vt[i].d, vt[i].n, vt[i].b, vt[i].lst);
            chk("lat_early", 128'(mv[vt[i].d]), 0);
            tick();
            chk("lat_valid", 128'(mv[vt[i].d]), 1);
            chk("vec_data", md[vt[i].d], vt[i].w);
            chk("vec_keep", 128'(mk[vt[i].d]), 128'(vt[i].k));
            chk("vec_last", 128'(ml[vt[i].d]), 128'(vt[i].lst));
            tick();
            chk("vec_drained", 128'(mv[vt[i].d]), 0);
        end

        // Fill to full with output stalled, then drain; three passes wrap.
        beat = 0;
        for (int p = 0; p < 3; p++) begin
            acc = 0;
            sv[2] = 1'b1;
            sl[2] = 1'b0;
            mr[2] = 1'b0;
            for (int c = 0; c < 60 && st[2]; c++) begin
                sd[2] = {16'hF00D, 16'(beat)};
                cyc2();
                if (last_acc) begin
                    beat++;
                    acc++;
                end
            end
            for (int c = 0; c < 8; c++) begin
                cyc2();
                if (last_acc) acc++;
            end
            chk("fill_accepted", 128'(acc), 32);
            chk("fill_level", 128'(lvl[2]), 4);
            chk("fill_pfull", 128'(pf[2]), 1);
            sv[2] = 1'b0;
            mr[2] = 1'b1;
            for (int c = 0; c < 20 && q.size() > 0; c++) cyc2();
            cyc2();
            chk("fill_drained", 128'(q.size()), 0);
        end

        acc = 0;
        last_acc = 1'b0;
        sv[2] = 1'b0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            if (!sv[2] || last_acc) begin
                sv[2] = 1'($urandom % 2);
                sd[2] = $urandom;
                sl[2] = ($urandom % 6) == 0;
            end
            mr[2] = 1'($urandom % 2);
            cyc2();
            if (last_acc) acc++;
        end
        chk("rand_beats", 128'(acc), 10000);
        sv[2] = 1'b0;
        mr[2] = 1'b1;
        for (int c = 0; c < 100 && q.size() > 0; c++) cyc2();
        chk("rand_drained", 128'(q.size()), 0);

        // Mid-operation reset: two queued words plus a partial word.
        mr[0] = 1'b0;
        send_pkt(0, 8, vt[0].b, 1'b1);
        send_pkt(0, 8, vt[0].b, 1'b1);
        send_pkt(0, 5, vt[0].b, 1'b0);
        chk("pre_rst_level", 128'(lvl[0]), 2);
        rst_n = 1'b0;
        tick();
        chk_reset(0);
        rst_n = 1'b1;
        mr[0] = 1'b1;
        tick();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (mv[0]) seen++;
            tick();
        end
        chk("no_stale", 128'(seen), 0);
        send_pkt(0, 8, vt[5].b, 1'b0);
        tick();
        chk("post_rst_valid", 128'(mv[0]), 1);
        chk("post_rst_data", md[0], vt[5].w);
        chk("post_rst_keep", 128'(mk[0]), 128'(8'hFF));
        chk("post_rst_last", 128'(ml[0]), 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/axis_upsizer_fifo.md
# axis_upsizer_fifo

Parametrised AXI-Stream width upsizer with built-in synchronous buffering. It is the successor to the fixed act/weight expanders in the conv front-end. It packs RATIO narrow lanes into one wide word and queues words in a DEPTH-entry FIFO. It adds tlast-driven partial-word flush with tkeep, selectable lane order, sub-word lane extraction and a programmable almost-full threshold. One instance is placed per stream (act: USE_W=16; weight: USE_W=32) between the DMA and the systolic array loaders.

## Interface
- IN_W, 32, width of input tdata bus
- USE_W, 16, bits taken from s_tdata[USE_W-1:0] per beat; USE_W ≤ IN_W
- OUT_W, 128, output word width; RATIO = OUT_W/USE_W, a power of two ≥ 1
- DEPTH, 512, FIFO depth in output words, power of two ≥ 4
- PF_THRESH, DEPTH-8, prog_full asserts when level ≥ PF_THRESH
- MSB_FIRST, 0, 0: first beat in lane 0 (bits [USE_W-1:0]); 1: first beat in lane RATIO-1
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid & s_tready
- s_tdata  in  IN_W  input data; bits above USE_W ignored
- s_tlast  in  1  last beat of packet
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream ready
- m_tdata  out  OUT_W  packed word
- m_tkeep  out  RATIO  one bit per lane; 1 = lane holds real data
- m_tlast  out  1  word contains the packet's last beat
- level  out  clog2(DEPTH+1)  words currently in FIFO (registered)
- prog_full  out  1  registered, level ≥ PF_THRESH

## Operation
- Packer: lane counter lc (0..RATIO-1), shift/assembly register, keep register.
  - An accepted beat writes s_tdata[USE_W-1:0] into lane lc (or lane RATIO-1-lc if MSB_FIRST) and sets that keep bit.
- A word is pushed when an accepted beat has lc==RATIO-1 or s_tlast=1.
  - Pushed word carries data, keep and tlast=s_tlast.
  - Unfilled lanes are zero, keep bits 0.
  - lc, assembly and keep registers clear on the same edge.
- FIFO: circular buffer with rd/wr pointers and a level counter, first-word-fall-through at the output.
- s_tready = (level != DEPTH). It is registered-derived and never depends combinationally on m_tready. The packer is therefore never blocked mid-push.
- Pop on m_tvalid & m_tready; simultaneous push and pop leaves level unchanged.
- RATIO==1: every beat is a word; m_tkeep is always 1.
- Reset values: s_tready=0, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, level=0, prog_full=0.
  - All pointers, lc and partial data clear.
  - s_tready rises on the first clk after rst_n returns high.
- Reset mid-operation discards the partial word and all queued words; no output follows until new input.

## Timing
- Push-to-valid latency: the beat completing a word at edge t makes m_tvalid high after edge t+1 when the FIFO was empty. With RATIO=8 that is 8 input beats + 1 cycle.
- m_tdata, m_tkeep and m_tlast are held stable while m_tvalid & ~m_tready.
- Throughput: one output word per cycle when m_tready=1 and the FIFO is non-empty.
- Input side: one beat per cycle while s_tready=1.
- level and prog_full update on the edge after a push or pop.
- Full boundary (level==DEPTH): s_tready=0. A pop on that cycle raises s_tready on the next cycle.
- Empty boundary: m_tvalid=0. m_tdata is don't-care, but the bench checks only when valid.
- Pointer wrap at DEPTH-1 → 0 must be transparent, with no lost or duplicated words.

## Structure
- Shared package `width_trans_pkg`:
  - clog2 helper function;
  - default width constants (ACT_USE_W=16, WEI_USE_W=32, ARRAY_W=128);
  - lane-index function honouring MSB_FIRST.
- One sub-module, `sync_fifo_fwft` (params WIDTH = OUT_W+RATIO+1, DEPTH), owning pointers, level and the output register. The top holds only the packer and the parameter checks.
- Elaboration-time assertions:
  - OUT_W % USE_W == 0;
  - RATIO a power of two;
  - PF_THRESH ≤ DEPTH.

## Test plan
1. Defaults (USE_W=16, OUT_W=128); 8 beats 0x0001..0x0008, last on beat 8, m_tready=1 → one word 0x0008_0007_..._0001, tkeep=0xFF, tlast=1, valid 1 cycle after beat 8.
2. MSB_FIRST=1, same stimulus → word 0x0001_0002_..._0008, tkeep=0xFF.
3. 3 beats 0xA, 0xB, 0xC with last on beat 3 → word 0x...000C_000B_000A, zero upper lanes, tkeep=0x07, tlast=1; the next packet starts at lane 0.
4. DEPTH=4, m_tready=0, stream 40 beats → s_tready falls after 32 accepted beats, level=4, prog_full follows PF_THRESH. Release m_tready → 4 words in order, wrap verified over 3 fill/drain passes.
5. Random s_tvalid/m_tready (50%), 10k beats with random tlast, checked against a scoreboard → no loss or duplication, and output held stable under backpressure.
6. Assert rst_n low for 1 cycle after 5 beats and 2 queued words → all outputs at reset values and no stale word emitted. The next 8 beats produce a clean word.
